// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port 64-bit data memory between the pipeline's EX/MEM
// stage (CPU port, single-beat, zero-cycle grant) and a DMA master that issues
// doubleword bursts with an auto-incrementing address. The memory port is
// driven combinationally from whichever requester owns the current cycle.
// cpu_stall freezes the pipeline whenever the CPU is requesting but locked out.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   CPU access request (held until granted)
//   cpu_gnt, cpu_stall      access performed this cycle / pipeline freeze
//   cpu_rvalid, cpu_rdata   registered load return, one cycle after grant
//   dma_req/we/addr/len     burst request; we/addr/len sampled at acceptance
//   dma_wdata               write data for the beat currently granted
//   dma_gnt, dma_done       beat performed this cycle / last-beat pulse
//   dma_rvalid, dma_rdata   registered read-beat return
//   mem_addr/write_data/write/read   Data_Memory request side
//   mem_read_data           Data_Memory read data, valid in the same cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [63:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [63:0] dma_addr,
    input  logic [3:0]  dma_len,
    input  logic [63:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [63:0] dma_rdata,
    output logic        dma_done,

    output logic [63:0] mem_addr,
    output logic [63:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_read_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_t           state_q,      state_d;
    logic [63:0]      base_q,       base_d;
    logic [3:0]       beat_q,       beat_d;
    logic [3:0]       last_q,       last_d;
    logic             we_l_q,       we_l_d;
    logic [CNT_W-1:0] starve_q,     starve_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic [63:0]      cpu_rdata_q,  cpu_rdata_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic [63:0]      dma_rdata_q,  dma_rdata_d;

    logic             dma_accept;
    logic             starve_full;
    logic [63:0]      burst_addr;

    assign starve_full = (starve_q == STARVE_MAX);
    assign burst_addr  = base_q + {57'd0, beat_q, 3'd0};

    // Arbitration and memory-port steering. Grants are gated with reset so the
    // memory port is quiet while reset is held, even if cpu_req is high.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cpu_gnt        = 1'b0;
        dma_gnt        = 1'b0;
        dma_accept     = 1'b0;
        dma_done       = 1'b0;
        mem_addr       = 64'd0;
        mem_write_data = 64'd0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;

        case (state_q)
            IDLE: begin
                if (reset) begin
                    if (cpu_req && !(dma_req && starve_full)) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_accept = 1'b1;
                    end
                end
            end
            BURST: begin
                dma_gnt  = 1'b1;
                dma_done = (beat_q == last_q);
            end
            default: ;
        endcase

        if (cpu_gnt) begin
            mem_addr       = cpu_addr;
            mem_write_data = cpu_wdata;
            mem_write      = cpu_we;
            mem_read       = ~cpu_we;
        end else if (dma_gnt) begin
            mem_addr       = burst_addr;
            mem_write_data = dma_wdata;
            mem_write      = we_l_q;
            mem_read       = ~we_l_q;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Next-state for the burst sequencer, fairness counter and read returns.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        beat_d   = beat_q;
        last_d   = last_q;
        we_l_d   = we_l_q;
        starve_d = starve_q;

        if (cpu_gnt && dma_req && !starve_full) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (dma_accept) begin
            state_d  = BURST;
            base_d   = dma_addr;
            we_l_d   = dma_we;
            beat_d   = 4'd0;
            // A zero length is a one-beat burst.
            last_d   = (dma_len == 4'd0) ? 4'd0 : dma_len - 4'd1;
            starve_d = '0;
        end

        if (dma_gnt) begin
            if (dma_done) begin
                state_d = IDLE;
            end else begin
                beat_d = beat_q + 4'd1;
            end
        end

        // Read data is captured only on a granted read; otherwise rdata holds.
        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        cpu_rdata_d  = cpu_rvalid_d ? mem_read_data : cpu_rdata_q;
        dma_rvalid_d = dma_gnt & ~we_l_q;
        dma_rdata_d  = dma_rvalid_d ? mem_read_data : dma_rdata_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            base_q       <= 64'd0;
            beat_q       <= 4'd0;
            last_q       <= 4'd0;
            we_l_q       <= 1'b0;
            starve_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 64'd0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            last_q       <= last_d;
            we_l_q       <= we_l_d;
            starve_q     <= starve_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a small behavioural data memory.
// Expected read data is queued when an access is issued and compared when the
// corresponding rvalid appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [63:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [63:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [63:0] dma_addr;
    logic [3:0]  dma_len;
    logic [63:0] dma_wdata;
    logic        dma_gnt, dma_rvalid, dma_done;
    logic [63:0] dma_rdata;
    logic [63:0] mem_addr, mem_write_data;
    logic        mem_write, mem_read;
    logic [63:0] mem_read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_gnt       (cpu_gnt),
        .cpu_stall     (cpu_stall),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_len       (dma_len),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_rvalid    (dma_rvalid),
        .dma_rdata     (dma_rdata),
        .dma_done      (dma_done),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .mem_read_data (mem_read_data)
    );

    // Behavioural memory: 32 doublewords selected by address bits [7:3].
    logic [63:0] mem_arr [32];
    assign mem_read_data = mem_arr[mem_addr[7:3]];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr[7:3]] <= mem_write_data;
    end

    int          total = 0;
    int          bad   = 0;
    logic [63:0] ref_mem [32];
    logic [63:0] cpu_q [$];
    logic [63:0] dma_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read-return scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        check("gnt_excl", 64'(cpu_gnt & dma_gnt), 64'd0);
        check("rw_excl", 64'(mem_read & mem_write), 64'd0);
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 64'(cpu_rvalid), 64'd0);
            else                   check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dma_rvalid) begin
            if (dma_q.size() == 0) check("dma_rvalid_unexpected", 64'(dma_rvalid), 64'd0);
            else                   check("dma_rdata", dma_rdata, dma_q.pop_front());
        end
    end

    // Uncontended single CPU access; called at posedge+1.
    task automatic cpu_op(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input string tag);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (we) ref_mem[addr[7:3]] = wdata;
        else    cpu_q.push_back(ref_mem[addr[7:3]]);
        @(negedge clk);
        check({tag, "_gnt"},   64'(cpu_gnt),   64'd1);
        check({tag, "_stall"}, 64'(cpu_stall), 64'd0);
        check({tag, "_addr"},  mem_addr,       addr);
        check({tag, "_wr"},    64'(mem_write), 64'(we));
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    // Uncontended DMA burst; beat k writes wbase+k. Called at posedge+1.
    task automatic dma_burst(input logic we, input logic [63:0] addr, input logic [3:0] len,
                             input logic [63:0] wbase, input string tag);
        int          n;
        logic [63:0] a;
        dma_req  = 1'b1;
        dma_we   = we;
        dma_addr = addr;
        dma_len  = len;
        @(negedge clk);
        check({tag, "_acc_gnt"}, 64'(dma_gnt), 64'd0);
        check({tag, "_acc_mem"}, 64'({mem_read, mem_write}), 64'd0);
        tick();
        dma_req = 1'b0;
        n = (len == 4'd0) ? 1 : int'(len);
        for (int k = 0; k < n; k++) begin
            a         = addr + 64'(k) * 64'd8;
            dma_wdata = wbase + 64'(k);
            if (we) ref_mem[a[7:3]] = dma_wdata;
            else    dma_q.push_back(ref_mem[a[7:3]]);
            @(negedge clk);
            check({tag, "_beat_gnt"},  64'(dma_gnt),   64'd1);
            check({tag, "_beat_addr"}, mem_addr,       a);
            check({tag, "_beat_wr"},   64'(mem_write), 64'(we));
            check({tag, "_beat_done"}, 64'(dma_done),  64'(k == n - 1));
            tick();
        end
        @(negedge clk);
        check({tag, "_end_gnt"},  64'(dma_gnt),  64'd0);
        check({tag, "_end_done"}, 64'(dma_done), 64'd0);
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 64'd0;
        cpu_wdata = 64'd0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = 64'd0;
        dma_len   = 4'd0;
        dma_wdata = 64'd0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;

        // Reset state.
        @(negedge clk);
        check("rst_outputs", 64'({cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid,
                                  dma_done, mem_write, mem_read}), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_rdata", cpu_rdata | dma_rdata, 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: CPU only.
        cpu_op(1'b1, 64'h10, 64'hDEAD, "t1_st");
        @(negedge clk);
        check("t1_st_no_rvalid", 64'(cpu_rvalid), 64'd0);
        tick();
        cpu_op(1'b0, 64'h10, 64'd0, "t1_ld");
        @(negedge clk);
        check("t1_rvalid", 64'(cpu_rvalid), 64'd1);
        check("t1_rdata", cpu_rdata, 64'hDEAD);
        tick();

        // 2: DMA write burst, then CPU readback.
        dma_burst(1'b1, 64'h40, 4'd4, 64'd1, "t2");
        for (int k = 0; k < 4; k++) cpu_op(1'b0, 64'h40 + 64'(k) * 64'd8, 64'd0, "t2_ld");
        tick();

        // 3: CPU contention during a len=3 read burst.
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 64'h40;
        dma_len  = 4'd3;
        @(negedge clk);
        check("t3_acc_gnt", 64'(dma_gnt), 64'd0);
        tick();
        dma_req = 1'b0;
        dma_q.push_back(ref_mem[8]);
        @(negedge clk);
        check("t3_b0_gnt", 64'(dma_gnt), 64'd1);
        tick();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 64'h48;
        dma_q.push_back(ref_mem[9]);
        @(negedge clk);
        check("t3_b1_stall", 64'(cpu_stall), 64'd1);
        check("t3_b1_cpu_gnt", 64'(cpu_gnt), 64'd0);
        check("t3_b1_dma_gnt", 64'(dma_gnt), 64'd1);
        tick();
        dma_q.push_back(ref_mem[10]);
        @(negedge clk);
        check("t3_b2_stall", 64'(cpu_stall), 64'd1);
        check("t3_b2_done", 64'(dma_done), 64'd1);
        check("t3_b2_addr", mem_addr, 64'h50);
        tick();
        cpu_q.push_back(ref_mem[9]);
        @(negedge clk);
        check("t3_idle_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("t3_idle_stall", 64'(cpu_stall), 64'd0);
        check("t3_idle_addr", mem_addr, 64'h48);
        tick();
        cpu_req = 1'b0;
        tick();

        // 4: starvation with both requests held high.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 64'h10;
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 64'h50;
        dma_len  = 4'd2;
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(ref_mem[2]);
            @(negedge clk);
            check("t4_cpu_gnt", 64'(cpu_gnt), 64'd1);
            check("t4_cpu_dma_gnt", 64'(dma_gnt), 64'd0);
            tick();
        end
        @(negedge clk);
        check("t4_acc_cpu_gnt", 64'(cpu_gnt), 64'd0);
        check("t4_acc_stall", 64'(cpu_stall), 64'd1);
        check("t4_acc_mem", 64'({mem_read, mem_write}), 64'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            dma_q.push_back(ref_mem[10 + k]);
            @(negedge clk);
            check("t4_beat_gnt", 64'(dma_gnt), 64'd1);
            check("t4_beat_stall", 64'(cpu_stall), 64'd1);
            check("t4_beat_addr", mem_addr, 64'h50 + 64'(k) * 64'd8);
            check("t4_beat_done", 64'(dma_done), 64'(k == 1));
            tick();
        end
        cpu_q.push_back(ref_mem[2]);
        @(negedge clk);
        check("t4_after_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("t4_after_dma_gnt", 64'(dma_gnt), 64'd0);
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();

        // 5: len=0 is one beat; address wraps past 2^64.
        dma_burst(1'b1, 64'h60, 4'd0, 64'hAA, "t5_len0");
        dma_burst(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4'd2, 64'hB1, "t5_wrap");
        cpu_op(1'b0, 64'h60, 64'd0, "t5_ld60");
        cpu_op(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, "t5_ldtop");
        cpu_op(1'b0, 64'h0, 64'd0, "t5_ld0");
        tick();
        check("t5_ref_wrap", ref_mem[0], 64'hB2);

        // 6: reset on beat 2 of a len=8 read burst.
        dma_req  = 1'b1;
        dma_we   = 1'b0;
        dma_addr = 64'h40;
        dma_len  = 4'd8;
        @(negedge clk);
        tick();
        dma_req = 1'b0;
        dma_q.push_back(ref_mem[8]);
        @(negedge clk);
        check("t6_b0_gnt", 64'(dma_gnt), 64'd1);
        tick();
        @(negedge clk);
        check("t6_b1_gnt", 64'(dma_gnt), 64'd1);
        tick();
        #1;
        reset    = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 64'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_rst_flags", 64'({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_done,
                                       mem_write, mem_read}), 64'd0);
            check("t6_rst_addr", mem_addr, 64'd0);
            check("t6_rst_rdata", dma_rdata, 64'd0);
            check("t6_rst_stall", 64'(cpu_stall), 64'd1);
            tick();
        end
        reset = 1'b1;
        cpu_q.push_back(ref_mem[2]);
        @(negedge clk);
        check("t6_post_cpu_gnt", 64'(cpu_gnt), 64'd1);
        check("t6_post_addr", mem_addr, 64'h10);
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        check("t6_post_rvalid", 64'(cpu_rvalid), 64'd1);
        tick();
        tick();
        tick();

        check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        check("dma_q_drained", 64'(dma_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and burst sequencer for the single-port 64-bit data memory of the 5-stage RISC-V pipeline. It shares the memory between two requesters:

- **CPU port:** the EX/MEM stage, single-beat accesses, zero-cycle grant.
- **DMA port:** a loader/debug master issuing doubleword bursts with an auto-incrementing address.

It drives the Data_Memory port directly and raises a stall to freeze the pipeline while the CPU is locked out.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive CPU grants, taken while DMA is pending, after which DMA wins the next arbitration.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  64  byte address (EXMEM result).
- cpu_wdata  in  64  store data.
- cpu_gnt  out  1  access performed this cycle (combinational).
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC, IF/ID, ID/EX and EX/MEM.
- cpu_rvalid  out  1  registered; load data valid.
- cpu_rdata  out  64  registered load data.
- dma_req  in  1  burst request; held until first dma_gnt.
- dma_we  in  1  burst direction, sampled at acceptance.
- dma_addr  in  64  burst base address, sampled at acceptance.
- dma_len  in  4  beat count, sampled at acceptance; 0 is treated as 1.
- dma_wdata  in  64  write data for the current beat; must be valid while dma_gnt=1.
- dma_gnt  out  1  one beat performed this cycle.
- dma_rvalid  out  1  registered; read beat data valid.
- dma_rdata  out  64  registered read beat data.
- dma_done  out  1  one-cycle pulse on the last beat.
- mem_addr  out  64  to Data_Memory mem_addr.
- mem_write_data  out  64  to Data_Memory write_data.
- mem_write  out  1  to Data_Memory mem_write.
- mem_read  out  1  to Data_Memory mem_read.
- mem_read_data  in  64  from Data_Memory read_data, valid in the same cycle.

## Operation

State machine with two states: IDLE and BURST.

**State registers:** base[63:0], beat[3:0], last[3:0], we_l, starve[CNT_W-1:0].

**IDLE:**
- CPU wins if cpu_req=1 and not (dma_req=1 and starve==STARVE_LIMIT).
  - Effect: cpu_gnt=1; mem_* is driven from the cpu_* inputs in the same cycle.
  - starve increments (saturating) if dma_req=1.
- Otherwise, if dma_req=1:
  - Latch base=dma_addr, we_l=dma_we, last=max(dma_len,1)-1, beat=0.
  - Clear starve and go to BURST.
  - No memory access occurs in this cycle.
- Otherwise, mem_read=mem_write=0 and mem_addr holds 0.

**BURST:**
- Each cycle: dma_gnt=1, mem_addr=base+(beat<<3) (mod 2^64, wrap allowed), mem_write=we_l, mem_read=~we_l, mem_write_data=dma_wdata.
- If beat==last: dma_done=1, go to IDLE. Otherwise beat increments.
- cpu_gnt=0 throughout, so cpu_stall=cpu_req.

**General rules:**
- cpu_gnt and dma_gnt are never both 1.
- mem_read and mem_write are never both 1.
- **Read return:** on the clock edge after a granted read, the requester's rvalid goes to 1 for one cycle and rdata captures mem_read_data. Otherwise rvalid=0 and rdata holds its value.
- Writes produce no rvalid.
- **CPU fairness:** after a burst ends, a pending cpu_req beats a re-asserted dma_req unless starve==STARVE_LIMIT. starve is 0 after any burst.

## Timing

- **Reset** (reset=0, asynchronous): state=IDLE; starve, beat, last, base and we_l = 0. All outputs are 0: gnt, rvalid, rdata, done, mem_*, and cpu_stall apart from its combinational term.
- **Reset mid-burst:** the burst is abandoned, no dma_done is issued, and a pending rvalid is dropped.
- **CPU latency:** 0 cycles to grant when uncontended; load data arrives 1 cycle after grant.
- **DMA latency:** 1 acceptance cycle, then len consecutive beat cycles.
- **Worst-case CPU stall:** 1 + 15 = 16 cycles per burst.
- **Starvation bound:** DMA waits at most STARVE_LIMIT CPU grants.
- **Simultaneous requests in IDLE** with starve<STARVE_LIMIT: the CPU is served and starve increments.
- **Request changes:** cpu_req falling before grant is legal and means no access. dma_* inputs changing during BURST are ignored except dma_wdata.

## Test plan

1. **CPU only:** store 0xDEAD to addr 0x10, then load 0x10 → cpu_gnt is 1 in the same cycles, cpu_stall=0, cpu_rvalid=1 one cycle after the load, cpu_rdata=0xDEAD.
2. **DMA write burst:** dma_addr=0x40, len=4, wdata 1..4; then CPU loads 0x40/0x48/0x50/0x58 → reads return 1, 2, 3, 4; dma_done is high exactly on the 4th beat, 5 cycles after dma_req.
3. **Contention during burst:** cpu_req rises on beat 1 of a len=3 read burst → cpu_stall=1 for the remaining beats; cpu_gnt is asserted in the first IDLE cycle after dma_done; no cycle has both grants set.
4. **Starvation:** cpu_req and dma_req held high continuously, STARVE_LIMIT=4 → CPU is granted 4 consecutive cycles, cycle 5 is DMA acceptance, then the burst runs, then the CPU is granted again.
5. **Boundary:** dma_len=0 at base 0xFFFF_FFFF_FFFF_FFF8 with len=2 in a second request → len 0 gives exactly 1 beat; the len=2 request accesses 0x...FFF8 then 0x0 (wrap).
6. **Reset mid-burst:** reset=0 on beat 2 of a len=8 burst → all outputs 0 immediately, no dma_done; after release, a cpu_req is granted in the first cycle.
